grid_snapshot_bridge: RTL and testbench

Parametrised memory-mapped bridge between the playfield grid logic and the Nios soft-processor in the tetris system. It captures a COLS×ROWS occupancy vector into a stable snapshot and runs a row-scan FSM that builds a full-row mask and count. It raises an interrupt on scan completion and exposes status, control and per-row words over an Avalon-MM slave. It is the next-generation replacement for the fixed 200-bit `grid_interface` conduit.

---
 rtl/grid_pkg.sv | 26 ++
 rtl/row_full_detect.sv | 12 +
 rtl/grid_snapshot_bridge.sv | 144 ++++++++++++++
 tb/tb_grid_snapshot_bridge.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// Shared definitions for the grid snapshot bridge: register map, bit positions,
// scan FSM encoding and the full-row counter width.
package grid_pkg;

  localparam int REG_STATUS    = 0;
  localparam int REG_CONTROL   = 1;
  localparam int REG_FULL_MASK = 2;
  localparam int REG_IRQ_CLR   = 3;
  localparam int REG_ROW0      = 4;

  localparam int ST_SNAP_VALID = 0;
  localparam int ST_BUSY       = 1;
  localparam int ST_IRQ_PEND   = 2;
  localparam int ST_COUNT_LSB  = 8;

  localparam int CTL_SNAP_REQ  = 0;
  localparam int CTL_IRQ_EN    = 1;
  localparam int CTL_AUTO_SNAP = 2;

  typedef enum logic [1:0] {S_IDLE, S_SNAP, S_SCAN, S_DONE} state_t;

  function automatic int cnt_width(input int rows);
    return $clog2(rows + 1);
  endfunction

endpackage

// File: rtl/row_full_detect.sv
// One snapshot row: all-ones detect for the scanner and zero-extended word for readback.
module row_full_detect #(
  parameter int COLS   = 10,
  parameter int DATA_W = 32
) (
  input  logic [COLS-1:0]   row,
  output logic              full,
  output logic [DATA_W-1:0] row_ext
);
  assign full    = &row;
  assign row_ext = DATA_W'(row);
endmodule

// File: rtl/grid_snapshot_bridge.sv
// Avalon-MM bridge: snapshots the playfield occupancy, scans it row by row for
// full lines and raises an interrupt when a fresh result is committed.
module grid_snapshot_bridge
  import grid_pkg::*;
#(
  parameter int COLS   = 10,
  parameter int ROWS   = 20,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [COLS*ROWS-1:0] grid_state,
  input  logic [ADDR_W-1:0]    avs_address,
  input  logic                 avs_read,
  output logic [DATA_W-1:0]    avs_readdata,
  input  logic                 avs_write,
  input  logic [DATA_W-1:0]    avs_writedata,
  output logic                 irq
);
  localparam int CNT_W  = cnt_width(ROWS);
  localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t                      state, next_state;
  logic [ROWS-1:0][COLS-1:0]   snap;
  logic [ROWS-1:0]             acc_mask, full_mask, full_vec;
  logic [CNT_W-1:0]            acc_cnt, full_count;
  logic [RIDX_W-1:0]           row_idx;
  logic                        snap_valid, irq_pending, pending;
  logic                        irq_en, auto_snap;
  logic [DATA_W-1:0]           row_ext [ROWS];
  logic [DATA_W-1:0]           rd_mux;
  logic                        ctl_wr, snap_req_wr, irq_clr_wr, busy, last_row;
  logic                        unused_wd;

  assign ctl_wr      = avs_write && (avs_address == ADDR_W'(REG_CONTROL));
  assign snap_req_wr = ctl_wr && avs_writedata[CTL_SNAP_REQ];
  assign irq_clr_wr  = avs_write && (avs_address == ADDR_W'(REG_IRQ_CLR)) && avs_writedata[0];
  assign busy        = (state != S_IDLE);
  assign last_row    = (row_idx == RIDX_W'(ROWS - 1));
  assign irq         = irq_pending && irq_en;
  assign unused_wd   = ^avs_writedata[DATA_W-1:3];

  for (genvar g = 0; g < ROWS; g++) begin : g_row
    row_full_detect #(.COLS(COLS), .DATA_W(DATA_W)) u_row (
      .row    (snap[g]),
      .full   (full_vec[g]),
      .row_ext(row_ext[g])
    );
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= S_IDLE;
    else                state <= next_state;
  end

  // Auto-snap compares against the live grid only while idle, so changes during
  // a scan are picked up on the first idle cycle.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: if (snap_req_wr || pending || (auto_snap && (grid_state != snap)))
                next_state = S_SNAP;
      S_SNAP: next_state = S_SCAN;
      S_SCAN: if (last_row) next_state = S_DONE;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      snap       <= '0;
      acc_mask   <= '0;
      acc_cnt    <= '0;
      row_idx    <= '0;
      full_mask  <= '0;
      full_count <= '0;
      snap_valid <= 1'b0;
    end else begin
      unique case (state)
        S_SNAP: begin
          snap     <= grid_state;
          acc_mask <= '0;
          acc_cnt  <= '0;
          row_idx  <= '0;
        end
        S_SCAN: begin
          acc_mask[row_idx] <= acc_mask[row_idx] | full_vec[row_idx];
          acc_cnt           <= acc_cnt + CNT_W'(full_vec[row_idx]);
          if (!last_row) row_idx <= row_idx + 1'b1;
        end
        S_DONE: begin
          full_mask  <= acc_mask;
          full_count <= acc_cnt;
          snap_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A request arriving while busy is held one-deep and launched from IDLE.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pending     <= 1'b0;
      irq_pending <= 1'b0;
      irq_en      <= 1'b0;
      auto_snap   <= 1'b0;
    end else begin
      if (state == S_IDLE)  pending <= 1'b0;
      else if (snap_req_wr) pending <= 1'b1;
      if (state == S_DONE)     irq_pending <= 1'b1;
      else if (irq_clr_wr)     irq_pending <= 1'b0;
      if (ctl_wr) begin
        irq_en    <= avs_writedata[CTL_IRQ_EN];
        auto_snap <= avs_writedata[CTL_AUTO_SNAP];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (avs_address == ADDR_W'(REG_STATUS)) begin
      rd_mux[ST_SNAP_VALID]              = snap_valid;
      rd_mux[ST_BUSY]                    = busy;
      rd_mux[ST_IRQ_PEND]                = irq_pending;
      rd_mux[ST_COUNT_LSB +: CNT_W]      = full_count;
    end else if (avs_address == ADDR_W'(REG_CONTROL)) begin
      rd_mux[CTL_IRQ_EN]    = irq_en;
      rd_mux[CTL_AUTO_SNAP] = auto_snap;
    end else if (avs_address == ADDR_W'(REG_FULL_MASK)) begin
      rd_mux = DATA_W'(full_mask);
    end
    for (int r = 0; r < ROWS; r++)
      if (avs_address == ADDR_W'(REG_ROW0 + r)) rd_mux = row_ext[r];
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)  avs_readdata <= '0;
    else if (avs_read)   avs_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_grid_snapshot_bridge.sv
// Directed bench for grid_snapshot_bridge at COLS=10, ROWS=20.
module tb_grid_snapshot_bridge;
  localparam int COLS = 10, ROWS = 20, DATA_W = 32, ADDR_W = 6;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [COLS*ROWS-1:0] grid = '0;
  logic [ADDR_W-1:0]    avs_address = '0;
  logic                 avs_read = 1'b0, avs_write = 1'b0;
  logic [DATA_W-1:0]    avs_writedata = '0, avs_readdata;
  logic                 irq;
  int                   n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  grid_snapshot_bridge #(.COLS(COLS), .ROWS(ROWS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .grid_state(grid),
    .avs_address(avs_address), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .irq(irq)
  );

  task automatic bus_write(input int a, input logic [31:0] d);
    @(negedge clk);
    avs_write = 1'b1; avs_address = 6'(a); avs_writedata = d;
    @(negedge clk);
    avs_write = 1'b0; avs_writedata = '0;
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    @(negedge clk);
    avs_read = 1'b1; avs_address = 6'(a);
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  // Streams STATUS reads; lead = idle samples before busy, cnt = busy samples.
  task automatic poll_busy(output int lead, output int cnt, output bit timeout);
    bit done = 1'b0;
    lead = 0; cnt = 0;
    avs_read = 1'b1; avs_address = 6'(0);
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (avs_readdata[1]) cnt++;
      else if (cnt > 0) done = 1'b1;
      else lead++;
    end
    avs_read = 1'b0;
    timeout = !done;
  endtask

  task automatic set_all_rows(input logic [9:0] v);
    for (int r = 0; r < ROWS; r++) grid[r*COLS +: COLS] = v;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #1;
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %h want 0", irq); end
    n_tests++; if (avs_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", avs_readdata); end
    @(negedge clk); rst_n = 1'b1;
    bus_read(0, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status got %h want 0", d); end
    bus_read(1, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_control got %h want 0", d); end
  endtask

  task automatic test_full_rows();
    logic [31:0] d; int lead, cnt; bit to;
    set_all_rows(10'h155);
    grid[19*COLS +: COLS] = 10'h3FF;
    grid[17*COLS +: COLS] = 10'h3FF;
    bus_write(1, 32'h1);
    poll_busy(lead, cnt, to);
    n_tests++; if (to || lead != 0 || cnt != 22) begin n_fail++; $display("FAIL full_busy got lead=%0d cnt=%0d to=%0d want 0/22/0", lead, cnt, to); end
    bus_read(2, d);
    n_tests++; if (d !== 32'h000A0000) begin n_fail++; $display("FAIL full_mask got %h want 000a0000", d); end
    bus_read(0, d);
    n_tests++; if (d !== 32'h00000205) begin n_fail++; $display("FAIL full_status got %h want 00000205", d); end
    bus_read(23, d);
    n_tests++; if (d !== 32'h3FF) begin n_fail++; $display("FAIL full_row19 got %h want 3ff", d); end
    bus_read(4, d);
    n_tests++; if (d !== 32'h155) begin n_fail++; $display("FAIL full_row0 got %h want 155", d); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_gated got %h want 0", irq); end
    bus_write(1, 32'h2);
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_enable got %h want 1", irq); end
    bus_write(3, 32'h1);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %h want 0", irq); end
    bus_read(0, d);
    n_tests++; if (d !== 32'h00000201) begin n_fail++; $display("FAIL irq_clr_status got %h want 00000201", d); end
    bus_write(1, 32'h3);
    repeat (21) @(negedge clk);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got %h want 0", irq); end
    avs_write = 1'b1; avs_address = 6'(3); avs_writedata = 32'h1;
    @(negedge clk);
    avs_write = 1'b0; avs_writedata = '0;
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins got %h want 1", irq); end
    bus_read(0, d);
    n_tests++; if (d !== 32'h00000205) begin n_fail++; $display("FAIL irq_set_status got %h want 00000205", d); end
  endtask

  task automatic test_bus_edges();
    logic [31:0] d;
    bus_read(24, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL bus_addr24 got %h want 0", d); end
    bus_read(63, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL bus_addr63 got %h want 0", d); end
    bus_write(0, 32'hFFFFFFFF);
    bus_read(0, d);
    n_tests++; if (d !== 32'h00000205) begin n_fail++; $display("FAIL bus_status_ro got %h want 00000205", d); end
    bus_read(1, d);
    n_tests++; if (d !== 32'h2) begin n_fail++; $display("FAIL bus_control got %h want 2", d); end
    bus_read(3, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL bus_irqclr_rd got %h want 0", d); end
    bus_write(1, 32'h0);
    bus_write(3, 32'h1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; int lead, cnt; bit to;
    bus_write(1, 32'h1);
    @(negedge clk);
    set_all_rows(10'h155);
    grid[5*COLS +: COLS] = 10'h3FF;
    bus_write(1, 32'h1);
    poll_busy(lead, cnt, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL b2b_first got timeout=%0d want 0", to); end
    poll_busy(lead, cnt, to);
    n_tests++; if (to || lead != 0 || cnt != 22) begin n_fail++; $display("FAIL b2b_second got lead=%0d cnt=%0d to=%0d want 0/22/0", lead, cnt, to); end
    bus_read(2, d);
    n_tests++; if (d !== 32'h20) begin n_fail++; $display("FAIL b2b_mask got %h want 20", d); end
    bus_read(9, d);
    n_tests++; if (d !== 32'h3FF) begin n_fail++; $display("FAIL b2b_row5 got %h want 3ff", d); end
    bus_read(23, d);
    n_tests++; if (d !== 32'h155) begin n_fail++; $display("FAIL b2b_row19 got %h want 155", d); end
    bus_read(0, d);
    n_tests++; if (d !== 32'h00000105) begin n_fail++; $display("FAIL b2b_status got %h want 00000105", d); end
  endtask

  task automatic test_auto_snap();
    logic [31:0] d; int lead, cnt, busy_seen; bit to;
    bus_write(1, 32'h4);
    @(negedge clk);
    grid[0] = ~grid[0];
    @(negedge clk);
    poll_busy(lead, cnt, to);
    n_tests++; if (to || lead != 0 || cnt != 22) begin n_fail++; $display("FAIL auto_busy got lead=%0d cnt=%0d to=%0d want 0/22/0", lead, cnt, to); end
    bus_read(4, d);
    n_tests++; if (d !== 32'h154) begin n_fail++; $display("FAIL auto_row0 got %h want 154", d); end
    busy_seen = 0;
    avs_read = 1'b1; avs_address = 6'(0);
    repeat (100) begin
      @(negedge clk);
      if (avs_readdata[1]) busy_seen++;
    end
    avs_read = 1'b0;
    n_tests++; if (busy_seen != 0) begin n_fail++; $display("FAIL auto_quiet got %0d busy cycles want 0", busy_seen); end
  endtask

  task automatic test_reset_midscan();
    logic [31:0] d;
    bus_write(1, 32'h2);
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rst_pre_irq got %h want 1", irq); end
    bus_write(1, 32'h3);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_mid_irq got %h want 0", irq); end
    n_tests++; if (avs_readdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_rdata got %h want 0", avs_readdata); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_read(0, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mid_status got %h want 0", d); end
    bus_read(2, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mid_mask got %h want 0", d); end
    bus_read(9, d);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_mid_row5 got %h want 0", d); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_post_irq got %h want 0", irq); end
  endtask

  initial begin
    test_reset();
    test_full_rows();
    test_irq();
    test_bus_edges();
    test_back_to_back();
    test_auto_snap();
    test_reset_midscan();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
